button_stepper: RTL and testbench
=================================

Name: button_stepper

Overview:
- Turns a raw, bouncing push-button into clean, fixed-width step pulses.
- Its output drives the single-cycle processor's step clock and the reset line in the board top level.
- It sits directly upstream of the processor: one instance serves the execute button, one serves the reset button.
- Adds hold-to-repeat, so a held execute button free-runs the core at a slow, visible rate.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on btn_in; must be ≥ 2.
- DEBOUNCE_CYCLES, 1_000_000, cycles btn_s must stay stable to accept a press or a release.
- PULSE_W, 4, width of each step_pulse in clk cycles; must be ≥ 1.
- HOLD_CYCLES, 50_000_000, cycles held in HELD before the first auto-repeat.
- REPEAT_CYCLES, 25_000_000, cycles between subsequent auto-repeats.
- REPEAT_EN, 1, 0 disables auto-repeat entirely.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous reset, active-high.
- btn_in, input, 1, raw asynchronous button level.
- step_pulse, output, 1, high for exactly PULSE_W cycles per accepted step.
- step_count, output, 16, total steps emitted; wraps around.
- held, output, 1, high in the FIRE and HELD states.
- repeating, output, 1, high once the first auto-repeat has fired, until release is accepted.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: all synchronizer flops 0, state IDLE, all counters 0, step_pulse 0, step_count 0, held 0, repeating 0.
- Reset asserted mid-pulse: step_pulse is 0 from the next edge; no partial-pulse completion.
- Synchronizer: btn_s is btn_in delayed through SYNC_STAGES flops. No other logic reads btn_in.
- All outputs are registered and derived from state/counters only (Moore).
- State machine, one counter cnt:
  - IDLE: btn_s=1 → PRESS_DB with cnt=0.
  - PRESS_DB: btn_s=0 → IDLE (bounce rejected). Otherwise cnt++; at cnt==DEBOUNCE_CYCLES-1 → FIRE with cnt=0 and step_count+1.
  - FIRE: step_pulse=1. cnt++; at cnt==PULSE_W-1 → HELD with cnt=0. btn_s is ignored, so a release during a pulse never shortens it.
  - HELD: btn_s=0 → RELEASE_DB with cnt=0. Otherwise cnt++.
    - If REPEAT_EN=1 and cnt reaches the threshold-1 → FIRE, step_count+1, repeating=1.
    - Threshold is HOLD_CYCLES when repeating=0, else REPEAT_CYCLES.
  - RELEASE_DB: btn_s=1 → HELD with cnt=0 (bounce; the hold timer restarts). Otherwise cnt++; at cnt==DEBOUNCE_CYCLES-1 → IDLE and repeating=0.
- Press-to-pulse latency: with btn_in stable high from edge k, step_pulse first reads 1 after edge k+SYNC_STAGES+DEBOUNCE_CYCLES+1. The bench checks this exactly.
- Pulse spacing in repeat mode: rising edge to rising edge is PULSE_W+REPEAT_CYCLES cycles; first repeat is at PULSE_W+HOLD_CYCLES.
- step_count arithmetic is unsigned modulo 2^16: 0xFFFF+1 = 0x0000.
- The counter is sized to $clog2 of the largest of DEBOUNCE_CYCLES, PULSE_W, HOLD_CYCLES, REPEAT_CYCLES; no overflow is possible.

Decomposition:
- Package stepper_pkg holds:
  - typedef enum logic [2:0] stepper_state_t {IDLE, PRESS_DB, FIRE, HELD, RELEASE_DB};
  - the step_count width constant STEP_CNT_W=16.
- One sub-module, input_synchronizer (parameter STAGES), is natural and reusable for other board inputs.
- The rest is a single FSM plus counter in button_stepper.

Test Plan (bench parameters SYNC_STAGES=2, DEBOUNCE_CYCLES=4, PULSE_W=3, HOLD_CYCLES=20, REPEAT_CYCLES=10):
- Clean press held 10 cycles, then released, REPEAT_EN=0 → step_pulse rises 7 edges after btn_in rises, stays high exactly 3 cycles; step_count=1; held falls after release debounce.
- Bounce: btn_in toggles 1,0,1,0 every 2 cycles, then stays 0 → no step_pulse, step_count=0, state returns to IDLE.
- Hold 80 cycles, REPEAT_EN=1 → pulses rise at t0, t0+23, t0+36, t0+49, …; repeating=1 from the second pulse; step_count increments once per pulse.
- Release glitch: btn_in dropped for 2 cycles while in HELD → no IDLE transition, no extra pulse; the hold timer restarts from 0.
- Reset asserted on the 2nd cycle of a pulse → step_pulse=0 and step_count=0 from the next edge; a fresh press afterwards behaves as the first scenario.
- step_count forced near wrap (65534 pulses, or a backdoor preload in the bench) → two more presses give 0xFFFF, then 0x0000.

Source files
------------

// File: rtl/button_stepper_pkg.sv
// Shared types and constants for the button stepper.
//   stepper_state_t : debounce / fire / hold state encoding
//   STEP_CNT_W      : width of the emitted-step counter
//   max4            : helper used to size the shared timing counter
package stepper_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        FIRE,
        HELD,
        RELEASE_DB
    } stepper_state_t;

    localparam int unsigned STEP_CNT_W = 16;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/button_stepper_if.sv
// Button-side bus of the stepper.
//   btn_in     : raw asynchronous button level (into the stepper)
//   step_pulse : fixed-width step pulse
//   step_count : total steps emitted, wraps
//   held       : button accepted and still held (FIRE/HELD)
//   repeating  : auto-repeat active
// slave is the stepper's view, master is the board/consumer view.
interface button_stepper_if;
    import stepper_pkg::*;

    logic                  btn_in;
    logic                  step_pulse;
    logic [STEP_CNT_W-1:0] step_count;
    logic                  held;
    logic                  repeating;

    modport master (
        output btn_in,
        input  step_pulse,
        input  step_count,
        input  held,
        input  repeating
    );

    modport slave (
        input  btn_in,
        output step_pulse,
        output step_count,
        output held,
        output repeating
    );

endinterface

// File: rtl/button_stepper_input_synchronizer.sv
// Multi-flop synchronizer for an asynchronous board input.
//   clk, reset : clock and synchronous active-high reset (flops clear to 0)
//   async_level: raw asynchronous level
//   sync_level : async_level delayed through STAGES flops
module input_synchronizer #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_level,
    output logic sync_level
);

    logic [STAGES-1:0] sync_q;

    // Shift chain; bit 0 is the metastability-exposed flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_level};
        end
    end

    assign sync_level = sync_q[STAGES-1];

endmodule

// File: rtl/button_stepper.sv
// Debounced push-button to fixed-width step pulses, with hold-to-repeat.
//   clk   : system clock
//   reset : synchronous reset, active-high
//   bus   : slave modport of button_stepper_if
//           (btn_in in; step_pulse, step_count, held, repeating out)
// All outputs are registered and depend only on state and counters.
module button_stepper
    import stepper_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned PULSE_W         = 4,
    parameter int unsigned HOLD_CYCLES     = 50_000_000,
    parameter int unsigned REPEAT_CYCLES   = 25_000_000,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    button_stepper_if.slave  bus
);

    localparam int unsigned CNT_MAX = max4(DEBOUNCE_CYCLES, PULSE_W, HOLD_CYCLES, REPEAT_CYCLES);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PW_LAST   = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic                  btn_s;
    stepper_state_t        state;
    logic [CNT_W-1:0]      cnt;
    logic [STEP_CNT_W-1:0] count_q;
    logic                  pulse_q;
    logic                  held_q;
    logic                  repeat_q;
    logic [CNT_W-1:0]      thr_last;

    input_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk         (clk),
        .reset       (reset),
        .async_level (bus.btn_in),
        .sync_level  (btn_s)
    );

    // First auto-repeat waits the long hold time, later ones the shorter period.
    assign thr_last = repeat_q ? REP_LAST : HOLD_LAST;

    // Debounce / fire / hold state machine with its shared timing counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            count_q  <= '0;
            pulse_q  <= 1'b0;
            held_q   <= 1'b0;
            repeat_q <= 1'b0;
        end else begin
            pulse_q <= (state == FIRE);
            held_q  <= (state == FIRE) || (state == HELD);

            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state <= PRESS_DB;
                        cnt   <= '0;
                    end
                end

                PRESS_DB: begin
                    if (!btn_s) begin
                        state <= IDLE;
                    end else if (cnt == DB_LAST) begin
                        state   <= FIRE;
                        cnt     <= '0;
                        count_q <= count_q + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Button level is deliberately ignored so a pulse is never cut short.
                FIRE: begin
                    if (cnt == PW_LAST) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                HELD: begin
                    if (!btn_s) begin
                        state <= RELEASE_DB;
                        cnt   <= '0;
                    end else if (REPEAT_EN) begin
                        if (cnt == thr_last) begin
                            state    <= FIRE;
                            cnt      <= '0;
                            count_q  <= count_q + 1'b1;
                            repeat_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                // A bounce back to 1 returns to HELD and restarts the hold timer.
                RELEASE_DB: begin
                    if (btn_s) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        repeat_q <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.step_pulse = pulse_q;
    assign bus.step_count = count_q;
    assign bus.held       = held_q;
    assign bus.repeating  = repeat_q;

endmodule

// File: tb/tb_button_stepper.sv
// Bench for button_stepper: two instances (auto-repeat on / off) share one
// button and reset; each scenario's per-cycle outputs are compared with a
// run-length reference model of the button rules, plus directed timing checks.
module tb_button_stepper;
    import stepper_pkg::*;

    localparam int S = 2;
    localparam int D = 4;
    localparam int P = 3;
    localparam int H = 20;
    localparam int R = 10;
    localparam int MAXN = 256;
    localparam int ST_IDLE = 0;
    localparam int ST_FIRE = 1;
    localparam int ST_HELD = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn = 1'b0;

    int tests = 0;
    int fails = 0;

    logic                  b [MAXN];
    int                    nb;
    logic                  o_pulse [2][MAXN];
    logic                  o_held  [2][MAXN];
    logic                  o_rep   [2][MAXN];
    logic [STEP_CNT_W-1:0] o_cnt   [2][MAXN];
    int                    st      [MAXN];
    bit                    fire_at [MAXN];
    bit                    rep_on  [MAXN];
    bit                    rep_off [MAXN];
    logic                  e_pulse [MAXN];
    logic                  e_held  [MAXN];
    logic                  e_rep   [MAXN];
    logic [STEP_CNT_W-1:0] e_cnt   [MAXN];
    logic [STEP_CNT_W-1:0] preload_val;

    always #5 clk = ~clk;

    button_stepper_if bus_a ();
    button_stepper_if bus_b ();

    assign bus_a.btn_in = btn;
    assign bus_b.btn_in = btn;

    button_stepper #(
        .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .PULSE_W(P),
        .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .REPEAT_EN(1'b1)
    ) dut_rep (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    button_stepper #(
        .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .PULSE_W(P),
        .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .REPEAT_EN(1'b0)
    ) dut_norep (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    // Button level as seen by the state machine at edge i.
    function automatic int sv(input int i);
        if (i < S || i - S >= nb) return 0;
        return b[i-S] ? 1 : 0;
    endfunction

    // First edge in [from, to] whose level differs from lvl, or -1.
    function automatic int first_not(input int from, input int to, input int lvl);
        for (int i = from; i <= to; i++) if (sv(i) != lvl) return i;
        return -1;
    endfunction

    function automatic void mark(input int a, input int z, input int v);
        for (int i = a; i <= z; i++) if (i >= 0 && i < nb) st[i] = v;
    endfunction

    // Reference: jump run-to-run through the button waveform and derive
    // the expected value of each output after every edge.
    function automatic void model(input bit rep_en, input logic [STEP_CNT_W-1:0] base);
        int t, e, k, f, h, x, y, thr;
        bit rep, done, r;
        logic [STEP_CNT_W-1:0] c;
        for (int i = 0; i < MAXN; i++) begin
            st[i] = ST_IDLE; fire_at[i] = 0; rep_on[i] = 0; rep_off[i] = 0;
        end
        t = 0;
        while (t < nb) begin
            if (sv(t) == 0) begin t++; continue; end
            e = t;
            k = first_not(e + 1, e + D, 1);
            if (k >= 0) begin t = k + 1; continue; end
            f = e + D; rep = 0; done = 0;
            while (!done) begin
                if (f < nb) fire_at[f] = 1;
                mark(f, f + P - 1, ST_FIRE);
                h = f + P;
                f = -1;
                while (f < 0 && !done) begin
                    thr = rep ? R : H;
                    x = first_not(h + 1, h + thr, 1);
                    if (x < 0 && rep_en) begin
                        mark(h, h + thr - 1, ST_HELD);
                        f = h + thr; rep = 1;
                        if (f < nb) rep_on[f] = 1;
                    end else begin
                        if (x < 0) x = first_not(h + 1, nb + S, 1);
                        mark(h, x - 1, ST_HELD);
                        y = first_not(x + 1, x + D, 0);
                        if (y >= 0) begin
                            h = y;
                        end else begin
                            if (x + D < nb) rep_off[x + D] = 1;
                            t = x + D + 1; done = 1;
                        end
                    end
                end
            end
        end
        c = base; r = 0;
        for (int i = 0; i < nb; i++) begin
            if (fire_at[i]) c = c + 1'b1;
            if (rep_on[i]) r = 1;
            if (rep_off[i]) r = 0;
            e_cnt[i]   = c;
            e_rep[i]   = r;
            e_pulse[i] = (i > 0) && (st[i-1] == ST_FIRE);
            e_held[i]  = (i > 0) && (st[i-1] != ST_IDLE);
        end
    endfunction

    task automatic check(input string tag, input int idx, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s @%0d got=%h exp=%h", tag, idx, got, exp);
        end
    endtask

    task automatic setb(input int a, input int z, input logic v);
        for (int i = a; i <= z; i++) b[i] = v;
    endtask

    // Reset both instances, then drive b[0..n-1], one level per edge.
    task automatic run(input int n, input int rst_at, input bit preload);
        nb = n;
        @(negedge clk);
        reset = 1'b1; btn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if (preload) begin
            force dut_rep.count_q = preload_val;
            force dut_norep.count_q = preload_val;
        end
        for (int i = 0; i < n; i++) begin
            btn = b[i];
            reset = (i == rst_at);
            @(posedge clk);
            #1;
            if (preload && i == 0) begin
                release dut_rep.count_q;
                release dut_norep.count_q;
            end
            o_pulse[0][i] = bus_a.step_pulse; o_held[0][i] = bus_a.held;
            o_rep[0][i]   = bus_a.repeating;  o_cnt[0][i]  = bus_a.step_count;
            o_pulse[1][i] = bus_b.step_pulse; o_held[1][i] = bus_b.held;
            o_rep[1][i]   = bus_b.repeating;  o_cnt[1][i]  = bus_b.step_count;
        end
        reset = 1'b0;
    endtask

    task automatic compare(input string name, input int rst_at, input logic [STEP_CNT_W-1:0] base);
        string dn;
        for (int d = 0; d < 2; d++) begin
            dn = (d == 0) ? "rep" : "norep";
            model(d == 0, base);
            for (int i = 0; i < nb; i++) begin
                if (rst_at >= 0 && i > rst_at) break;
                if (i == rst_at) begin
                    e_pulse[i] = 0; e_held[i] = 0; e_rep[i] = 0; e_cnt[i] = '0;
                end
                check($sformatf("%s.%s.pulse", name, dn), i, 16'(o_pulse[d][i]), 16'(e_pulse[i]));
                check($sformatf("%s.%s.held", name, dn),  i, 16'(o_held[d][i]),  16'(e_held[i]));
                check($sformatf("%s.%s.rep", name, dn),   i, 16'(o_rep[d][i]),   16'(e_rep[i]));
                check($sformatf("%s.%s.count", name, dn), i, o_cnt[d][i], e_cnt[i]);
            end
        end
    endtask

    function automatic int rise(input int d, input int nth);
        int seen;
        seen = 0;
        for (int i = 0; i < nb; i++) begin
            if (o_pulse[d][i] && (i == 0 || !o_pulse[d][i-1])) begin
                seen++;
                if (seen == nth) return i;
            end
        end
        return -1;
    endfunction

    function automatic int ones(input int d);
        int c;
        c = 0;
        for (int i = 0; i < nb; i++) if (o_pulse[d][i]) c++;
        return c;
    endfunction

    initial begin
        int lvl, p, len;

        // Clean press, released after 10 cycles.
        setb(0, MAXN - 1, 1'b0); setb(0, 9, 1'b1);
        run(40, -1, 1'b0);
        compare("press", -1, '0);
        check("press.latency", 0, 16'(rise(1, 1)), 16'd7);
        check("press.width", 0, 16'(ones(1)), 16'd3);
        check("press.count", 39, o_cnt[1][39], 16'd1);
        check("press.held_end", 39, 16'(o_held[1][39]), 16'd0);

        // Bouncing press never accepted.
        setb(0, MAXN - 1, 1'b0); setb(0, 1, 1'b1); setb(4, 5, 1'b1);
        run(30, -1, 1'b0);
        compare("bounce", -1, '0);
        check("bounce.pulses", 0, 16'(ones(0)), 16'd0);
        check("bounce.count", 29, o_cnt[0][29], 16'd0);

        // Long hold: auto-repeat spacing.
        setb(0, MAXN - 1, 1'b0); setb(0, 79, 1'b1);
        run(120, -1, 1'b0);
        compare("hold", -1, '0);
        check("hold.first", 0, 16'(rise(0, 1)), 16'd7);
        check("hold.gap1", 0, 16'(rise(0, 2) - rise(0, 1)), 16'd23);
        check("hold.gap2", 0, 16'(rise(0, 3) - rise(0, 2)), 16'd13);
        check("hold.rep_first", 7, 16'(o_rep[0][rise(0, 1)]), 16'd0);
        check("hold.rep_second", 30, 16'(o_rep[0][rise(0, 2)]), 16'd1);
        check("hold.norep_count", 119, o_cnt[1][119], 16'd1);

        // Short release glitch while held restarts the hold timer.
        setb(0, MAXN - 1, 1'b0); setb(0, 14, 1'b1); setb(17, 44, 1'b1);
        run(80, -1, 1'b0);
        compare("glitch", -1, '0);
        check("glitch.second_rise", 0, 16'(rise(0, 2)), 16'd40);
        check("glitch.norep_count", 79, o_cnt[1][79], 16'd1);

        // Reset on the second cycle of a pulse, then a fresh press.
        setb(0, MAXN - 1, 1'b1);
        run(20, 9, 1'b0);
        compare("rstmid", 9, '0);
        check("rstmid.before", 8, 16'(o_pulse[1][8]), 16'd1);
        check("rstmid.after", 9, 16'(o_pulse[1][9]), 16'd0);
        setb(0, MAXN - 1, 1'b0); setb(0, 9, 1'b1);
        run(40, -1, 1'b0);
        compare("repress", -1, '0);
        check("repress.latency", 0, 16'(rise(1, 1)), 16'd7);
        check("repress.count", 39, o_cnt[1][39], 16'd1);

        // Step counter wrap from a preloaded value.
        preload_val = 16'hFFFE;
        setb(0, MAXN - 1, 1'b0); setb(0, 9, 1'b1); setb(22, 31, 1'b1);
        run(50, -1, 1'b1);
        compare("wrap", -1, 16'hFFFE);
        check("wrap.first", 20, o_cnt[1][20], 16'hFFFF);
        check("wrap.second", 49, o_cnt[1][49], 16'h0000);

        // Random button waveforms with mixed short (bounce) and long runs.
        for (int r = 0; r < 6; r++) begin
            lvl = int'($urandom_range(0, 1));
            p = 0;
            while (p < 180) begin
                len = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 6)) : int'($urandom_range(5, 40));
                for (int i = p; i < p + len && i < MAXN; i++) b[i] = lvl[0];
                p += len;
                lvl = 1 - lvl;
            end
            run(180, -1, 1'b0);
            compare($sformatf("rand%0d", r), -1, '0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
